score_pulser: RTL and testbench
===============================

SCORE_PULSER -- requirements
Module: score_pulser

Interface
REQ-001 Parameter HOLDOFF, default 8, minimum clk cycles between accepted score events (range 1..255).
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 start  input  1  level; begin or restart a game.
REQ-005 pass  input  1  level; high while bird is clearing a pipe, may stay high many cycles.
REQ-006 crash  input  1  level; collision detected.
REQ-007 up_ones  output  1  one-cycle pulse to the ones-digit display counter.
REQ-008 up_tens  output  1  one-cycle pulse to the tens-digit display counter.
REQ-009 ones  output  4  BCD ones digit of current score, 0..9.
REQ-010 tens  output  4  BCD tens digit of current score, 0..9.
REQ-011 best_ones  output  4  BCD ones digit of best score.
REQ-012 best_tens  output  4  BCD tens digit of best score.
REQ-013 playing  output  1  high while in PLAY state.
REQ-014 saturated  output  1  high while current score equals 99.

Function
REQ-015 FSM states IDLE, PLAY, OVER; all outputs and state registered.
REQ-016 IDLE: start=1 -> PLAY; ones, tens, holdoff counter cleared on the same edge.
REQ-017 PLAY: crash=1 -> OVER; start ignored.
REQ-018 OVER: start=1 -> PLAY; score cleared on the same edge; best retained.
REQ-019 prev_pass register samples pass every cycle in every state.
REQ-020 Score event: state PLAY, pass=1, prev_pass=0, holdoff counter=0, crash=0.
REQ-021 crash and a score event edge in the same cycle: crash wins, edge discarded, no pulse.
REQ-022 Event with ones<9: ones+1; up_ones=1 for exactly the next cycle.
REQ-023 Event with ones=9, tens<9: ones=0, tens+1; up_ones and up_tens both 1 for the same next cycle.
REQ-024 Event with score 99: score unchanged, no pulses, saturated stays 1.
REQ-025 Latency: rising edge of pass sampled at edge N -> ones/tens and pulses updated at edge N+1 (pass first high in cycle before edge N).
REQ-026 Accepted event loads holdoff counter with HOLDOFF; counter decrements by 1 per cycle to 0, saturating at 0.
REQ-027 Rising edges of pass while counter nonzero are dropped, never queued.
REQ-028 Pass held high generates exactly one event regardless of duration.
REQ-029 On PLAY->OVER transition edge: if {tens,ones} > {best_tens,best_ones} (tens compared first) best <= score, else best unchanged.
REQ-030 Score frozen in OVER and IDLE; pulses never asserted outside PLAY.
REQ-031 up_ones/up_tens default 0 every cycle unless REQ-022/023 apply; never high two consecutive cycles.
REQ-032 saturated = (tens==9 && ones==9), registered alongside score.

Reset
REQ-033 reset=1 at edge: state IDLE; ones, tens, best_ones, best_tens, holdoff counter, prev_pass = 0; up_ones, up_tens, playing, saturated = 0.
REQ-034 reset overrides start, pass, crash in the same cycle, including mid-game and mid-holdoff; best score is lost.

Verification
REQ-035 Reset, start 1 cycle, pass pulsed 3 times spaced 20 cycles -> 3 single up_ones pulses, ones=3, tens=0, no up_tens.
REQ-036 Score 09, pass edge -> next cycle up_ones=1 and up_tens=1 together, ones=0, tens=1.
REQ-037 HOLDOFF=8: two pass edges 4 cycles apart -> one event; third edge 10 cycles after first -> accepted.
REQ-038 pass held high 50 cycles in PLAY -> exactly one up_ones pulse.
REQ-039 Score 42, crash with simultaneous pass edge -> OVER, score 42, no pulse, best=42; restart, score 17, crash -> best stays 42.
REQ-040 Score 99, pass edge -> no pulses, saturated=1; reset asserted mid-holdoff in PLAY -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/score_pulser.sv
// Two-digit BCD score keeper for a flappy-style game: counts pass edges with a holdoff
// window, emits per-digit increment pulses and remembers the best score across games.
module score_pulser #(
    parameter int unsigned HOLDOFF = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pass,
    input  logic       crash,
    output logic       up_ones,
    output logic       up_tens,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] best_ones,
    output logic [3:0] best_tens,
    output logic       playing,
    output logic       saturated
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLDOFF);

    state_t     state_q, state_d;
    logic [3:0] ones_q, ones_d, tens_q, tens_d;
    logic [3:0] best_ones_q, best_ones_d, best_tens_q, best_tens_d;
    logic [7:0] hold_q, hold_d;
    logic       prev_pass_q, prev_pass_d;
    logic       ev_q, ev_d;
    logic       up_ones_q, up_ones_d, up_tens_q, up_tens_d;
    logic       playing_q, playing_d, saturated_q, saturated_d;

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        best_ones_d = best_ones_q;
        best_tens_d = best_tens_q;
        hold_d      = (hold_q != 8'd0) ? hold_q - 8'd1 : 8'd0;
        prev_pass_d = pass;
        ev_d        = 1'b0;
        up_ones_d   = 1'b0;
        up_tens_d   = 1'b0;

        case (state_q)
            PLAY: begin
                if (crash) begin
                    // a pending event is dropped: crash always wins
                    state_d = OVER;
                    if ({tens_q, ones_q} > {best_tens_q, best_ones_q}) begin
                        best_tens_d = tens_q;
                        best_ones_d = ones_q;
                    end
                end else begin
                    if (ev_q && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
                        up_ones_d = 1'b1;
                        if (ones_q == 4'd9) begin
                            ones_d    = 4'd0;
                            tens_d    = tens_q + 4'd1;
                            up_tens_d = 1'b1;
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end
                    // detected event is applied one edge later to give the score its latency
                    if (pass && !prev_pass_q && hold_q == 8'd0) begin
                        ev_d   = 1'b1;
                        hold_d = HOLD_LD;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = PLAY;
                    ones_d  = 4'd0;
                    tens_d  = 4'd0;
                    hold_d  = 8'd0;
                end
            end
        endcase

        playing_d   = (state_d == PLAY);
        saturated_d = (tens_d == 4'd9) && (ones_d == 4'd9);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            best_ones_q <= 4'd0;
            best_tens_q <= 4'd0;
            hold_q      <= 8'd0;
            prev_pass_q <= 1'b0;
            ev_q        <= 1'b0;
            up_ones_q   <= 1'b0;
            up_tens_q   <= 1'b0;
            playing_q   <= 1'b0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            best_ones_q <= best_ones_d;
            best_tens_q <= best_tens_d;
            hold_q      <= hold_d;
            prev_pass_q <= prev_pass_d;
            ev_q        <= ev_d;
            up_ones_q   <= up_ones_d;
            up_tens_q   <= up_tens_d;
            playing_q   <= playing_d;
            saturated_q <= saturated_d;
        end
    end

    assign up_ones   = up_ones_q;
    assign up_tens   = up_tens_q;
    assign ones      = ones_q;
    assign tens      = tens_q;
    assign best_ones = best_ones_q;
    assign best_tens = best_tens_q;
    assign playing   = playing_q;
    assign saturated = saturated_q;

endmodule

// File: tb/tb_score_pulser.sv
// Bench for score_pulser: directed game scenarios followed by random play, every cycle
// compared against an integer-score reference model.
module tb_score_pulser;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset, start, pass, crash;
    logic       up_ones, up_tens, playing, saturated;
    logic [3:0] ones, tens, best_ones, best_tens;

    score_pulser #(.HOLDOFF(H)) dut (
        .clk(clk), .reset(reset), .start(start), .pass(pass), .crash(crash),
        .up_ones(up_ones), .up_tens(up_tens), .ones(ones), .tens(tens),
        .best_ones(best_ones), .best_tens(best_tens),
        .playing(playing), .saturated(saturated)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: game state, score as a plain integer
    int m_st = 0;          // 0 idle, 1 play, 2 over
    int m_score = 0, m_best = 0, m_hold = 0;
    bit m_prev = 0, m_pend = 0, m_uo = 0, m_ut = 0;
    int n_uo = 0, n_ut = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit p, input bit c);
        bit ev_now;
        if (r) begin
            m_st = 0; m_score = 0; m_best = 0; m_hold = 0;
            m_prev = 0; m_pend = 0; m_uo = 0; m_ut = 0;
            return;
        end
        m_uo = 0; m_ut = 0;
        ev_now = (m_st == 1) && p && !m_prev && (m_hold == 0) && !c;
        if (m_pend && m_st == 1 && !c && m_score < 99) begin
            m_uo = 1;
            m_ut = (m_score % 10 == 9);
            m_score++;
        end
        if (ev_now) m_hold = H;
        else if (m_hold > 0) m_hold--;
        if (m_st == 1 && c) begin
            if (m_score > m_best) m_best = m_score;
            m_st = 2;
        end else if (m_st != 1 && s) begin
            m_score = 0; m_hold = 0; m_st = 1;
        end
        m_pend = ev_now;
        m_prev = p;
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit c);
        reset = r; start = s; pass = p; crash = c;
        @(posedge clk);
        model_edge(r, s, p, c);
        #1;
        if (up_ones === 1'b1) n_uo++;
        if (up_tens === 1'b1) n_ut++;
        chk("ones", 8'(ones), 8'(m_score % 10));
        chk("tens", 8'(tens), 8'(m_score / 10));
        chk("best_ones", 8'(best_ones), 8'(m_best % 10));
        chk("best_tens", 8'(best_tens), 8'(m_best / 10));
        chk("up_ones", 8'(up_ones), 8'(m_uo));
        chk("up_tens", 8'(up_tens), 8'(m_ut));
        chk("playing", 8'(playing), 8'(m_st == 1));
        chk("saturated", 8'(saturated), 8'(m_score == 99));
    endtask

    task automatic score_one();
        cyc(0, 0, 1, 0);
        repeat (H + 2) cyc(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1; start = 0; pass = 0; crash = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        chk("reset_playing", 8'(playing), 8'd0);
        chk("reset_ones", 8'(ones), 8'd0);

        // three spaced passes
        cyc(0, 1, 0, 0);
        n_uo = 0; n_ut = 0;
        repeat (3) begin
            cyc(0, 0, 1, 0);
            repeat (19) cyc(0, 0, 0, 0);
        end
        chk("three_ones", 8'(ones), 8'd3);
        chk("three_tens", 8'(tens), 8'd0);
        chk("three_up_ones", 8'(n_uo), 8'd3);
        chk("three_up_tens", 8'(n_ut), 8'd0);

        // carry 09 -> 10
        repeat (6) score_one();
        chk("at_nine", 8'(ones), 8'd9);
        cyc(0, 0, 1, 0);
        chk("carry_latency", 8'(up_ones), 8'd0);
        cyc(0, 0, 0, 0);
        chk("carry_up_ones", 8'(up_ones), 8'd1);
        chk("carry_up_tens", 8'(up_tens), 8'd1);
        chk("carry_ones", 8'(ones), 8'd0);
        chk("carry_tens", 8'(tens), 8'd1);
        repeat (H + 2) cyc(0, 0, 0, 0);

        // holdoff: edges at 0, 4, 10 -> two events
        n_uo = 0;
        for (int i = 0; i <= 10; i++) cyc(0, 0, (i == 0 || i == 4 || i == 10), 0);
        repeat (H + 2) cyc(0, 0, 0, 0);
        chk("holdoff_events", 8'(n_uo), 8'd2);
        chk("holdoff_score", 8'(ones), 8'd2);

        // pass held 50 cycles
        n_uo = 0;
        repeat (50) cyc(0, 0, 1, 0);
        repeat (H + 2) cyc(0, 0, 0, 0);
        chk("held_events", 8'(n_uo), 8'd1);

        // score 42, crash with pass edge
        repeat (29) score_one();
        chk("s42_tens", 8'(tens), 8'd4);
        n_uo = 0;
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk("crash_no_pulse", 8'(n_uo), 8'd0);
        chk("crash_ones", 8'(ones), 8'd2);
        chk("best_42_tens", 8'(best_tens), 8'd4);
        chk("best_42_ones", 8'(best_ones), 8'd2);
        cyc(0, 1, 0, 0);
        repeat (17) score_one();
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        chk("restart_cleared", 8'(ones), 8'd0);
        chk("best_kept_tens", 8'(best_tens), 8'd4);
        chk("best_kept_ones", 8'(best_ones), 8'd2);

        // saturate at 99, then reset mid-holdoff
        repeat (99) score_one();
        chk("sat_flag", 8'(saturated), 8'd1);
        n_uo = 0; n_ut = 0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("sat_no_up_ones", 8'(n_uo), 8'd0);
        chk("sat_no_up_tens", 8'(n_ut), 8'd0);
        chk("sat_still", 8'(saturated), 8'd1);
        chk("sat_tens", 8'(tens), 8'd9);
        cyc(1, 0, 0, 0);
        chk("rst_mid_playing", 8'(playing), 8'd0);
        chk("rst_mid_sat", 8'(saturated), 8'd0);
        chk("rst_mid_best", 8'(best_tens), 8'd0);

        // random play
        begin
            bit p = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 3) == 0) p = ~p;
                cyc($urandom_range(0, 599) == 0, $urandom_range(0, 29) == 0, p,
                    $urandom_range(0, 79) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
